// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module : conv_pkg
// Brief  : Shared defaults, FSM state type and word-packing helper for the
//          convolution PE sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package conv_pkg;

  localparam int NUM_PE_DFLT           = 16;
  localparam int CYCLES_PER_PIXEL_DFLT = 36;
  localparam int NUM_PIXELS_DFLT       = 3136;
  localparam int START_DELAY_DFLT      = 3;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    PE_RST     = 3'd2,
    ACCUM      = 3'd3,
    FINISH     = 3'd4,
    DRAIN      = 3'd5
  } state_t;

  // The lowest-numbered lane of a group lands in the most significant byte.
  function automatic logic [31:0] pack_word(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2,
                                            input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofm_packer.sv
`default_nettype none
// ============================================================================
// Module : ofm_packer
// Brief  : Captures a full OFM lane vector and writes it out as 32-bit words,
//          one word per cycle, with a running write address and drop flag.
// Rev    : 1.0  initial release
// ============================================================================
module ofm_packer
  import conv_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic [NUM_PE-1:0]     valid_i,
  input  logic [NUM_PE*8-1:0]   ofm_i,
  output logic                  wr_en_o,
  output logic [31:0]           addr_o,
  output logic [31:0]           data_o,
  output logic [1:0]            mux_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int         c_GROUPS   = NUM_PE / 4;
  localparam logic [1:0] c_LAST_GRP = 2'(c_GROUPS - 1);

  logic [NUM_PE*8-1:0] buf_q;
  logic                wr_en_q;
  logic [1:0]          grp_q;
  logic [31:0]         addr_q;
  logic [31:0]         data_q;
  logic                ovf_q;

  logic                w_trigger;
  logic [NUM_PE*8-1:0] w_src;
  logic [1:0]          w_sel;
  logic [31:0]         w_words [4];
  logic [31:0]         w_word;

  assign w_trigger = &valid_i;

  // Word 0 comes straight from the input on the trigger edge; later words
  // come from the captured copy.
  assign w_src  = wr_en_q ? buf_q : ofm_i;
  assign w_sel  = wr_en_q ? grp_q + 2'd1 : 2'd0;
  assign w_word = w_words[w_sel];

  for (genvar g = 0; g < 4; g++) begin : g_words
    if (g < c_GROUPS) begin : g_used
      assign w_words[g] = pack_word(w_src[8*(4*g)   +: 8],
                                    w_src[8*(4*g+1) +: 8],
                                    w_src[8*(4*g+2) +: 8],
                                    w_src[8*(4*g+3) +: 8]);
    end else begin : g_pad
      assign w_words[g] = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q   <= '0;
      wr_en_q <= 1'b0;
      grp_q   <= 2'd0;
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en_q) begin
        addr_q <= addr_q + 32'd1;
      end
      if (clear_i) begin
        addr_q <= 32'd0;
        ovf_q  <= 1'b0;
      end
      if (wr_en_q) begin
        if (w_trigger) begin
          ovf_q <= 1'b1;
        end
        if (grp_q == c_LAST_GRP) begin
          wr_en_q <= 1'b0;
          grp_q   <= 2'd0;
        end else begin
          grp_q  <= grp_q + 2'd1;
          data_q <= w_word;
        end
      end else if (w_trigger) begin
        buf_q   <= ofm_i;
        wr_en_q <= 1'b1;
        grp_q   <= 2'd0;
        data_q  <= w_word;
      end
    end
  end

  assign wr_en_o    = wr_en_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign mux_o      = grp_q;
  assign busy_o     = wr_en_q | w_trigger;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/conv_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : conv_pe_sequencer
// Brief  : Sequences PE reset/finish strobes per OFM pixel and forwards the
//          PE array results to the next-layer BRAM through ofm_packer.
// Rev    : 1.0  initial release
// ============================================================================
module conv_pe_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_PE           = NUM_PE_DFLT,
  parameter int CYCLES_PER_PIXEL = CYCLES_PER_PIXEL_DFLT,
  parameter int NUM_PIXELS       = NUM_PIXELS_DFLT,
  parameter int START_DELAY      = START_DELAY_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cal_start,
  output logic [NUM_PE-1:0]     PE_reset,
  output logic [NUM_PE-1:0]     PE_finish,
  input  logic [NUM_PE-1:0]     valid,
  input  logic [NUM_PE*8-1:0]   ofm_in,
  output logic                  wr_en_next,
  output logic [31:0]           addr_ram_next_wr,
  output logic [31:0]           data_ram_next,
  output logic [1:0]            control_mux,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int c_DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int c_CW = $clog2(CYCLES_PER_PIXEL);
  localparam int c_PW = $clog2(NUM_PIXELS + 1);

  state_t          state_q, state_d;
  logic [c_DW-1:0] dly_q, dly_d;
  logic [c_CW-1:0] cyc_q, cyc_d;
  logic [c_PW-1:0] pix_q, pix_d;

  logic            w_start;
  logic            w_wb_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      cyc_q   <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      cyc_q   <= cyc_d;
      pix_q   <= pix_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cyc_d     = cyc_q;
    pix_d     = pix_q;
    PE_reset  = '0;
    PE_finish = '0;
    done      = 1'b0;
    w_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cal_start) begin
          w_start = 1'b1;
          state_d = WAIT_START;
          dly_d   = '0;
          cyc_d   = '0;
          pix_d   = '0;
        end
      end
      WAIT_START: begin
        if (dly_q == c_DW'(START_DELAY - 1)) begin
          state_d = PE_RST;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      PE_RST: begin
        PE_reset = '1;
        cyc_d    = '0;
        state_d  = ACCUM;
      end
      // Two of the pixel's clocks belong to PE_RST and FINISH.
      ACCUM: begin
        if (cyc_q == c_CW'(CYCLES_PER_PIXEL - 3)) begin
          state_d = FINISH;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      FINISH: begin
        PE_finish = '1;
        pix_d     = pix_q + 1'b1;
        state_d   = (pix_d < c_PW'(NUM_PIXELS)) ? PE_RST : DRAIN;
      end
      DRAIN: begin
        if (!w_wb_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  ofm_packer #(
    .NUM_PE (NUM_PE)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (w_start),
    .valid_i    (valid),
    .ofm_i      (ofm_in),
    .wr_en_o    (wr_en_next),
    .addr_o     (addr_ram_next_wr),
    .data_o     (data_ram_next),
    .mux_o      (control_mux),
    .busy_o     (w_wb_busy),
    .overflow_o (overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_pe_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_conv_pe_sequencer
// Brief  : Self-checking bench: directed and randomised stimulus compared
//          against a cycle-indexed behavioural model of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_conv_pe_sequencer;

  localparam int NPE  = 16;
  localparam int CPP  = 36;
  localparam int NPIX = 4;
  localparam int SD   = 3;
  localparam int G    = NPE / 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cal_start = 1'b0;
  logic [NPE-1:0]   valid = '0;
  logic [NPE*8-1:0] ofm_in = '0;
  logic [NPE-1:0]   PE_reset, PE_finish;
  logic             wr_en_next, busy, done, overflow;
  logic [31:0]      addr_ram_next_wr, data_ram_next;
  logic [1:0]       control_mux;

  always #5 clk = ~clk;

  conv_pe_sequencer #(
    .NUM_PE           (NPE),
    .CYCLES_PER_PIXEL (CPP),
    .NUM_PIXELS       (NPIX),
    .START_DELAY      (SD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cal_start        (cal_start),
    .PE_reset         (PE_reset),
    .PE_finish        (PE_finish),
    .valid            (valid),
    .ofm_in           (ofm_in),
    .wr_en_next       (wr_en_next),
    .addr_ram_next_wr (addr_ram_next_wr),
    .data_ram_next    (data_ram_next),
    .control_mux      (control_mux),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [1:0]  mux;
  } wr_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          edge_n = 0;

  // Reference model: everything is indexed by absolute cycle number.
  wr_t         wq[$];
  bit          run, done_prev, wr_prev, ovf;
  int          base, wb_last;
  logic [31:0] cur_addr;
  logic [15:0] p_v;
  bit          p_s;
  logic [7:0]  p_b   [NPE];
  logic [7:0]  cur_b [NPE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; done_prev = 0; wr_prev = 0; ovf = 0;
    base = 0; wb_last = -100; cur_addr = 32'd0;
    wq.delete();
    p_v = '0; p_s = 0;
    for (int k = 0; k < NPE; k++) p_b[k] = 8'h00;
  endtask

  task automatic model_edge();
    bit started;
    started = p_s && !run;
    if (done_prev) run = 0;
    done_prev = 0;
    if (wr_prev) cur_addr = cur_addr + 32'd1;
    wr_prev = 0;
    if (started) begin
      run = 1; base = edge_n + SD; ovf = 0; cur_addr = 32'd0;
    end
    if (p_v == 16'hFFFF) begin
      if (wb_last >= edge_n - 1) ovf = 1;
      else begin
        for (int g = 0; g < G; g++)
          wq.push_back('{edge_n + g, {p_b[4*g], p_b[4*g+1], p_b[4*g+2], p_b[4*g+3]}, 2'(g)});
        wb_last = edge_n + G - 1;
      end
    end
  endtask

  task automatic model_check();
    bit  exp_wr, exp_rst, exp_fin, exp_done;
    int  t;
    wr_t w;
    exp_wr = (wq.size() > 0) && (wq[0].cyc == edge_n);
    chk("wr_en", 64'(wr_en_next), 64'(exp_wr));
    if (exp_wr) begin
      w = wq.pop_front();
      chk("data", 64'(data_ram_next), 64'(w.data));
      chk("mux", 64'(control_mux), 64'(w.mux));
      wr_prev = 1;
    end
    chk("addr", 64'(addr_ram_next_wr), 64'(cur_addr));
    chk("overflow", 64'(overflow), 64'(ovf));
    chk("busy", 64'(busy), 64'(run));
    exp_rst = 0; exp_fin = 0; exp_done = 0;
    if (run) begin
      t = edge_n - base;
      if (t >= 0) begin
        if (t / CPP < NPIX) begin
          exp_rst = (t % CPP == 0);
          exp_fin = (t % CPP == CPP - 1);
        end else begin
          exp_done = (wb_last < edge_n) && (valid != 16'hFFFF);
        end
      end
    end
    chk("PE_reset", 64'(PE_reset), 64'({NPE{exp_rst}}));
    chk("PE_finish", 64'(PE_finish), 64'({NPE{exp_fin}}));
    chk("done", 64'(done), 64'(exp_done));
    done_prev = exp_done;
  endtask

  task automatic tick(input logic [15:0] v, input bit s);
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    valid = v;
    cal_start = s;
    for (int k = 0; k < NPE; k++) ofm_in[8*k +: 8] = cur_b[k];
    #1;
    model_check();
    p_v = v; p_s = s;
    for (int k = 0; k < NPE; k++) p_b[k] = cur_b[k];
  endtask

  task automatic rand_bytes();
    for (int k = 0; k < NPE; k++) cur_b[k] = 8'($urandom);
  endtask

  function automatic logic [15:0] partial_valid();
    logic [15:0] v;
    v = 16'($urandom);
    if (v == 16'hFFFF) v = 16'hFFFE;
    return v;
  endfunction

  task automatic do_reset();
    valid = '0; cal_start = 1'b0; reset = 1'b1;
    #1;
    chk("rst_PE_reset", 64'(PE_reset), 64'd0);
    chk("rst_PE_finish", 64'(PE_finish), 64'd0);
    chk("rst_wr_en", 64'(wr_en_next), 64'd0);
    chk("rst_data", 64'(data_ram_next), 64'd0);
    chk("rst_addr", 64'(addr_ram_next_wr), 64'd0);
    chk("rst_mux", 64'(control_mux), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #3 reset = 1'b0;
    model_reset();
  endtask

  // One all-ones valid per pixel at phase 5; stops on done, or at the given
  // offset from the first PE_reset when stop_at >= 0.
  task automatic run_pixels(input int budget, input int stop_at);
    bit          seen;
    int          ph;
    logic [15:0] v;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      ph = edge_n + 1 - base;
      rand_bytes();
      if (run && ph >= 0 && ph / CPP < NPIX && ph % CPP == 5) v = 16'hFFFF;
      else v = partial_valid();
      tick(v, 1'b0);
      if (stop_at < 0 && done === 1'b1) seen = 1;
      if (stop_at >= 0 && run && edge_n - base == stop_at) seen = 1;
    end
    chk("reached_within_budget", 64'(seen), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int k = 0; k < NPE; k++) cur_b[k] = 8'h00;
    do_reset();
    repeat (3) tick(16'h0000, 1'b0);

    // Known lane pattern 0x00..0x0F
    for (int k = 0; k < NPE; k++) cur_b[k] = 8'(k);
    tick(16'hFFFF, 1'b0);
    repeat (6) tick(16'h0000, 1'b0);
    chk("addr_after_burst", 64'(addr_ram_next_wr), 64'd4);

    // Partial valid is ignored
    tick(16'h7FFF, 1'b0);
    repeat (3) tick(16'h0000, 1'b0);
    chk("addr_after_partial", 64'(addr_ram_next_wr), 64'd4);

    // Second trigger while writing is dropped
    rand_bytes();
    tick(16'hFFFF, 1'b0);
    tick(16'h0000, 1'b0);
    rand_bytes();
    tick(16'hFFFF, 1'b0);
    repeat (6) tick(16'h0000, 1'b0);
    chk("overflow_set", 64'(overflow), 64'd1);
    chk("addr_after_drop", 64'(addr_ram_next_wr), 64'd8);

    // Full run of NPIX pixels
    tick(16'h0000, 1'b1);
    run_pixels(NPIX * CPP + 40, -1);
    tick(16'h0000, 1'b0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("addr_after_run", 64'(addr_ram_next_wr), 64'd16);
    chk("overflow_cleared", 64'(overflow), 64'd0);

    // Reset in the middle of pixel 2, then restart from scratch
    tick(16'h0000, 1'b1);
    run_pixels(3 * CPP + 20, 2 * CPP + 10);
    do_reset();
    repeat (2) tick(16'h0000, 1'b0);
    chk("addr_after_abort", 64'(addr_ram_next_wr), 64'd0);
    tick(16'h0000, 1'b1);
    run_pixels(NPIX * CPP + 40, -1);
    tick(16'h0000, 1'b0);
    chk("addr_after_restart", 64'(addr_ram_next_wr), 64'd16);

    // Random traffic: triggers, partials and start pulses in any state
    for (int i = 0; i < 700; i++) begin
      int          r;
      logic [15:0] v;
      r = int'($urandom_range(0, 15));
      rand_bytes();
      if (r == 0) v = 16'hFFFF;
      else if (r < 8) v = partial_valid();
      else v = 16'h0000;
      tick(v, ($urandom_range(0, 59) == 0));
    end
    repeat (5) tick(16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_pe_sequencer.md
CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

Interface
REQ-001 Parameters: NUM_PE, 16, PE lanes (multiple of 4); CYCLES_PER_PIXEL, 36, clocks per OFM pixel (>=8); NUM_PIXELS, 3136, OFM pixels per channel group (56x56); START_DELAY, 3, clocks from cal_start capture to first PE_reset.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cal_start  input  1  start request, sampled in IDLE only.
REQ-005 PE_reset  output  NUM_PE  per-lane accumulator clear.
REQ-006 PE_finish  output  NUM_PE  per-lane end-of-pixel strobe.
REQ-007 valid  input  NUM_PE  per-lane OFM-byte-ready flags from the PE array.
REQ-008 ofm_in  input  NUM_PE*8  OFM bytes; lane k at bits [8k+7:8k].
REQ-009 wr_en_next  output  1  next-layer BRAM write enable.
REQ-010 addr_ram_next_wr  output  32  next-layer BRAM word address.
REQ-011 data_ram_next  output  32  packed OFM word.
REQ-012 control_mux  output  2  index of the word group being written.
REQ-013 busy  output  1  high outside IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 overflow  output  1  sticky error flag.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_START, PE_RST, ACCUM, FINISH, DRAIN.
REQ-017 In IDLE, cal_start=1 at edge N SHALL enter WAIT_START; PE_reset SHALL be all-ones for exactly the cycle following edge N+START_DELAY.
REQ-018 Each pixel period SHALL be CYCLES_PER_PIXEL clocks: PE_RST 1 cycle (PE_reset all-ones), ACCUM CYCLES_PER_PIXEL-2 cycles (both strobes zero), FINISH 1 cycle (PE_finish all-ones).
REQ-019 After FINISH, the pixel counter SHALL increment; if below NUM_PIXELS, PE_RST SHALL follow with no gap, otherwise DRAIN.
REQ-020 cal_start SHALL be ignored outside IDLE.
REQ-021 The writeback path SHALL trigger only when valid equals all-ones; partial valid patterns SHALL be ignored.
REQ-022 On trigger, ofm_in SHALL be captured and NUM_PE/4 words written on consecutive cycles starting the next cycle, control_mux = 0,1,2,...
REQ-023 Word g SHALL be {lane 4g, lane 4g+1, lane 4g+2, lane 4g+3}, lane 4g in bits [31:24].
REQ-024 addr_ram_next_wr SHALL start at 0 after reset/start and increment by 1 after each write; wrap at 2^32 is permitted.
REQ-025 A trigger arriving while a writeback is in progress SHALL be dropped and SHALL set overflow until reset or next accepted cal_start.
REQ-026 Writeback SHALL operate in any state, including IDLE.
REQ-027 DRAIN SHALL wait until no writeback is in progress, then pulse done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 While reset is high: state IDLE; PE_reset, PE_finish, wr_en_next, data_ram_next, addr_ram_next_wr, control_mux, done, busy, overflow, pixel and cycle counters all 0.
REQ-030 Reset asserted mid-pixel or mid-writeback SHALL abort immediately; no further write SHALL occur after release until a new trigger.

Structure
REQ-031 NUM_PE, CYCLES_PER_PIXEL, NUM_PIXELS, START_DELAY defaults and the FSM state enum SHALL live in package conv_pkg.
REQ-032 Writeback (capture, packing, address counter, overflow) SHALL be sub-module ofm_packer; the FSM and counters stay in the top.

Verification
REQ-033 cal_start pulse at edge 10 -> PE_reset all-ones in cycle after edge 13, PE_finish all-ones 35 cycles later, next PE_reset the following cycle.
REQ-034 valid=16'hFFFF for one cycle with ofm_in lanes 0..15 = 8'h00..8'h0F -> writes 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F at addresses 0..3, control_mux 0..3, wr_en_next high exactly 4 cycles.
REQ-035 valid=16'h7FFF -> no write, address unchanged.
REQ-036 Two all-ones valid triggers 2 cycles apart -> second dropped, overflow=1, exactly 4 writes.
REQ-037 NUM_PIXELS=4 with one valid per pixel -> 16 writes at addresses 0..15, done single pulse after last write, busy low after.
REQ-038 reset asserted during ACCUM of pixel 2 -> all outputs 0 next cycle; cal_start restarts at pixel 0, address 0.
